// File: rtl/shifter_arbiter_if.sv
// shifter_arbiter_if
// Groups the request handshakes, the shifter drive/return bus and the response
// bus of shifter_arbiter.
//   req0_* / req1_*  : valid/ready request ports carrying data, type and shamt
//   sh_*             : operands to, and result from, the shared barrel shifter
//   resp_*, result   : one-cycle tagged response and registered result
//   busy             : arbiter is not idle
// The slave modport is the arbiter side; the master modport is the
// requester/shifter/environment side.
interface shifter_arbiter_if #(
    parameter int DATA_W  = 8,
    parameter int SHAMT_W = 5,
    parameter int TYPE_W  = 3
);
    logic               req0_valid;
    logic [DATA_W-1:0]  req0_data;
    logic [TYPE_W-1:0]  req0_type;
    logic [SHAMT_W-1:0] req0_shamt;
    logic               req0_ready;

    logic               req1_valid;
    logic [DATA_W-1:0]  req1_data;
    logic [TYPE_W-1:0]  req1_type;
    logic [SHAMT_W-1:0] req1_shamt;
    logic               req1_ready;

    logic [DATA_W-1:0]  sh_data_in;
    logic [TYPE_W-1:0]  sh_type;
    logic [SHAMT_W-1:0] sh_shamt;
    logic [DATA_W-1:0]  sh_data_out;

    logic               resp_valid;
    logic               resp_id;
    logic [DATA_W-1:0]  result;
    logic               busy;

    modport slave (
        input  req0_valid, req0_data, req0_type, req0_shamt,
        output req0_ready,
        input  req1_valid, req1_data, req1_type, req1_shamt,
        output req1_ready,
        output sh_data_in, sh_type, sh_shamt,
        input  sh_data_out,
        output resp_valid, resp_id, result, busy
    );

    modport master (
        output req0_valid, req0_data, req0_type, req0_shamt,
        input  req0_ready,
        output req1_valid, req1_data, req1_type, req1_shamt,
        input  req1_ready,
        input  sh_data_in, sh_type, sh_shamt,
        output sh_data_out,
        input  resp_valid, resp_id, result, busy
    );
endinterface

// File: rtl/shifter_arbiter.sv
// shifter_arbiter
// Shares one combinational barrel shifter between two requesters using
// round-robin arbitration. The winner's operands are latched, presented to the
// shifter for one full cycle, and the shifter output is registered and returned
// with a one-cycle response pulse tagged with the owning port.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : shifter_arbiter_if.slave (requests, shifter bus, response, busy)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | arbitrate; the granted port sees ready and may transfer
// SHIFT  | latched operands drive the shifter; result captured at edge
// RESP   | resp_valid high for this cycle only, then back to IDLE
module shifter_arbiter #(
    parameter int DATA_W  = 8,
    parameter int SHAMT_W = 5,
    parameter int TYPE_W  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    shifter_arbiter_if.slave    bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]         state;
    logic               last_grant;
    logic               owner;
    logic [DATA_W-1:0]  op_data;
    logic [TYPE_W-1:0]  op_type;
    logic [SHAMT_W-1:0] op_shamt;
    logic [DATA_W-1:0]  result_q;
    logic               resp_id_q;

    logic               grant_valid;
    logic               grant_id;
    logic               xfer;

    // Round-robin: under contention the port that did not win last time goes.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = ~last_grant;
            end else if (bus.req0_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b0;
            end else if (bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_id    = 1'b1;
            end
        end
    end

    // Ready only asserts toward a port that is valid, so ready implies transfer.
    assign bus.req0_ready = grant_valid && !grant_id;
    assign bus.req1_ready = grant_valid &&  grant_id;
    assign xfer           = grant_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_data    <= '0;
            op_type    <= '0;
            op_shamt   <= '0;
            result_q   <= '0;
            resp_id_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (grant_id) begin
                            op_data  <= bus.req1_data;
                            op_type  <= bus.req1_type;
                            op_shamt <= bus.req1_shamt;
                        end else begin
                            op_data  <= bus.req0_data;
                            op_type  <= bus.req0_type;
                            op_shamt <= bus.req0_shamt;
                        end
                        owner      <= grant_id;
                        last_grant <= grant_id;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    result_q  <= bus.sh_data_out;
                    resp_id_q <= owner;
                    state     <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Operand registers feed the shifter in every state; only SHIFT matters.
    assign bus.sh_data_in = op_data;
    assign bus.sh_type    = op_type;
    assign bus.sh_shamt   = op_shamt;

    assign bus.resp_valid = (state == RESP);
    assign bus.resp_id    = resp_id_q;
    assign bus.result     = result_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_shifter_arbiter.sv
// tb_shifter_arbiter
// Directed bench for shifter_arbiter. The shifter is modelled as
// data_out = data_in + {type, shamt} (8-bit wrap). Inputs change on the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_shifter_arbiter;
    localparam int DATA_W  = 8;
    localparam int SHAMT_W = 5;
    localparam int TYPE_W  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shifter_arbiter_if #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W), .TYPE_W(TYPE_W)) bus ();

    assign bus.sh_data_out = bus.sh_data_in + {bus.sh_type, bus.sh_shamt};

    shifter_arbiter #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W), .TYPE_W(TYPE_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            bus.req0_data  = 8'($urandom);
            bus.req0_type  = 3'($urandom);
            bus.req0_shamt = 5'($urandom);
            bus.req1_data  = 8'($urandom);
            bus.req1_type  = 3'($urandom);
            bus.req1_shamt = 5'($urandom);
            #1;
            checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
            checks++; if (bus.resp_id !== 1'b0) begin errors++; $display("FAIL rst_resp_id: got %b want 0", bus.resp_id); end
            checks++; if (bus.result !== 8'h00) begin errors++; $display("FAIL rst_result: got %h want 00", bus.result); end
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
            checks++; if (bus.sh_data_in !== 8'h00) begin errors++; $display("FAIL rst_sh_data_in: got %h want 00", bus.sh_data_in); end
            checks++; if (bus.sh_type !== 3'd0) begin errors++; $display("FAIL rst_sh_type: got %h want 0", bus.sh_type); end
            checks++; if (bus.sh_shamt !== 5'd0) begin errors++; $display("FAIL rst_sh_shamt: got %h want 0", bus.sh_shamt); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("FAIL rst_idle_ready0: got %b want 0", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL rst_idle_ready1: got %b want 0", bus.req1_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_data = 8'hCA; bus.req0_type = 3'b011; bus.req0_shamt = 5'd3;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0: got %b want 1", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1: got %b want 0", bus.req1_ready); end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        checks++; if (bus.sh_data_in !== 8'hCA) begin errors++; $display("FAIL single_sh_data_in: got %h want ca", bus.sh_data_in); end
        checks++; if (bus.sh_type !== 3'd3) begin errors++; $display("FAIL single_sh_type: got %h want 3", bus.sh_type); end
        checks++; if (bus.sh_shamt !== 5'd3) begin errors++; $display("FAIL single_sh_shamt: got %h want 3", bus.sh_shamt); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_shift: got %b want 1", bus.busy); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL single_early_resp: got %b want 0", bus.resp_valid); end
        @(negedge clk);
        #1;
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL single_resp_valid: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_id !== 1'b0) begin errors++; $display("FAIL single_resp_id: got %b want 0", bus.resp_id); end
        checks++; if (bus.result !== 8'h2D) begin errors++; $display("FAIL single_result: got %h want 2d", bus.result); end
        @(negedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b want 0", bus.busy); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL single_resp_after: got %b want 0", bus.resp_valid); end
    endtask

    task automatic test_contention();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_data = 8'h10; bus.req0_type = 3'd0; bus.req0_shamt = 5'd1;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h0F; bus.req1_type = 3'd1; bus.req1_shamt = 5'd2;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL cont_first_ready0: got %b want 1", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL cont_first_ready1: got %b want 0", bus.req1_ready); end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL cont_shift_ready1: got %b want 0", bus.req1_ready); end
        @(negedge clk);
        #1;
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL cont_resp0_valid: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_id !== 1'b0) begin errors++; $display("FAIL cont_resp0_id: got %b want 0", bus.resp_id); end
        checks++; if (bus.result !== 8'h11) begin errors++; $display("FAIL cont_resp0_result: got %h want 11", bus.result); end
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL cont_resp_ready1: got %b want 0", bus.req1_ready); end
        @(negedge clk);
        #1;
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL cont_second_ready1: got %b want 1", bus.req1_ready); end
        @(negedge clk);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL cont_resp1_valid: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_id !== 1'b1) begin errors++; $display("FAIL cont_resp1_id: got %b want 1", bus.resp_id); end
        checks++; if (bus.result !== 8'h31) begin errors++; $display("FAIL cont_resp1_result: got %h want 31", bus.result); end
    endtask

    task automatic test_sustained();
        int gcount = 0;
        int rcount = 0;
        logic [3:0] gseq = '0;
        logic [3:0] rseq = '0;
        logic [7:0] want;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus.req0_valid = 1'b1; bus.req0_data = 8'h01; bus.req0_type = 3'd0; bus.req0_shamt = 5'd0;
                bus.req1_valid = 1'b1; bus.req1_data = 8'h80; bus.req1_type = 3'd0; bus.req1_shamt = 5'd0;
            end
            #1;
            checks++; if ((bus.req0_ready & bus.req1_ready) !== 1'b0) begin errors++; $display("FAIL sust_onehot c%0d: got %b%b want not both", c, bus.req0_ready, bus.req1_ready); end
            if (bus.req0_ready === 1'b1 && gcount < 4) begin gseq[gcount] = 1'b0; gcount++; end
            else if (bus.req1_ready === 1'b1 && gcount < 4) begin gseq[gcount] = 1'b1; gcount++; end
            if (bus.resp_valid === 1'b1) begin
                want = (bus.resp_id === 1'b1) ? 8'h80 : 8'h01;
                checks++; if (bus.result !== want) begin errors++; $display("FAIL sust_result c%0d: got %h want %h", c, bus.result, want); end
                if (rcount < 4) rseq[rcount] = bus.resp_id;
                rcount++;
            end
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        checks++; if (gcount !== 4) begin errors++; $display("FAIL sust_grant_count: got %0d want 4", gcount); end
        checks++; if (gseq !== 4'b1010) begin errors++; $display("FAIL sust_grant_order: got %b want 1010 (lsb first)", gseq); end
        checks++; if (rcount !== 4) begin errors++; $display("FAIL sust_resp_count: got %0d want 4", rcount); end
        checks++; if (rseq !== 4'b1010) begin errors++; $display("FAIL sust_resp_order: got %b want 1010 (lsb first)", rseq); end
    endtask

    task automatic test_hold();
        int pulses = 0;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_data = 8'h55; bus.req0_type = 3'd0; bus.req0_shamt = 5'd0;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL hold_ready0: got %b want 1", bus.req0_ready); end
        if (bus.resp_valid === 1'b1) pulses++;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_data = 8'h20; bus.req1_type = 3'd2; bus.req1_shamt = 5'd4;
        #1;
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL hold_ready1_shift: got %b want 0", bus.req1_ready); end
        if (bus.resp_valid === 1'b1) pulses++;
        @(negedge clk);
        #1;
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("FAIL hold_ready1_resp: got %b want 0", bus.req1_ready); end
        checks++; if (bus.result !== 8'h55) begin errors++; $display("FAIL hold_result0: got %h want 55", bus.result); end
        if (bus.resp_valid === 1'b1) pulses++;
        @(negedge clk);
        #1;
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL hold_ready1_idle: got %b want 1", bus.req1_ready); end
        if (bus.resp_valid === 1'b1) pulses++;
        @(negedge clk);
        bus.req1_valid = 1'b0;
        #1;
        if (bus.resp_valid === 1'b1) pulses++;
        @(negedge clk);
        #1;
        checks++; if (bus.resp_id !== 1'b1) begin errors++; $display("FAIL hold_resp1_id: got %b want 1", bus.resp_id); end
        checks++; if (bus.result !== 8'h64) begin errors++; $display("FAIL hold_result1: got %h want 64", bus.result); end
        if (bus.resp_valid === 1'b1) pulses++;
        @(negedge clk);
        #1;
        if (bus.resp_valid === 1'b1) pulses++;
        checks++; if (pulses !== 2) begin errors++; $display("FAIL hold_pulse_count: got %0d want 2", pulses); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_data = 8'h33; bus.req0_type = 3'd1; bus.req0_shamt = 5'd1;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL mid_ready0: got %b want 1", bus.req0_ready); end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_shift: got %b want 1", bus.busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy_rst: got %b want 0", bus.busy); end
        checks++; if (bus.result !== 8'h00) begin errors++; $display("FAIL mid_result_rst: got %h want 00", bus.result); end
        checks++; if (bus.sh_data_in !== 8'h00) begin errors++; $display("FAIL mid_sh_data_rst: got %h want 00", bus.sh_data_in); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_resp_rst: got %b want 0", bus.resp_valid); end
        @(negedge clk);
        #1;
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_resp_hold: got %b want 0", bus.resp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.req1_valid = 1'b1; bus.req1_data = 8'h0F; bus.req1_type = 3'd1; bus.req1_shamt = 5'd2;
        #1;
        checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL mid_after_ready1: got %b want 1", bus.req1_ready); end
        @(negedge clk);
        bus.req1_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL mid_after_resp: got %b want 1", bus.resp_valid); end
        checks++; if (bus.resp_id !== 1'b1) begin errors++; $display("FAIL mid_after_id: got %b want 1", bus.resp_id); end
        checks++; if (bus.result !== 8'h31) begin errors++; $display("FAIL mid_after_result: got %h want 31", bus.result); end
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_type = '0; bus.req0_shamt = '0;
        bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_type = '0; bus.req1_shamt = '0;
        test_reset();
        test_single();
        test_contention();
        test_sustained();
        test_hold();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
